// File: rtl/gin_multicast_buffer_ctrl_if.sv
// Bus-side packet handshake and PE-side drain handshake of the GIN multicast buffer.
interface gin_multicast_buffer_ctrl_if #(
  parameter int unsigned ID_LEN    = 4,
  parameter int unsigned VALUE_LEN = 32
);
  logic [ID_LEN-1:0]    tag;
  logic                 in_valid;
  logic                 in_ready;
  logic [VALUE_LEN-1:0] value_in;
  logic                 out_valid;
  logic                 out_ready;
  logic [VALUE_LEN-1:0] value_out;

  modport master (
    output tag, in_valid, value_in, out_ready,
    input  in_ready, out_valid, value_out
  );

  modport slave (
    input  tag, in_valid, value_in, out_ready,
    output in_ready, out_valid, value_out
  );
endinterface

// File: rtl/gin_multicast_buffer_ctrl.sv
// Range-matching GIN leaf controller: stores packets whose tag lies in [id_lo, id_hi]
// in a small FIFO and drains them to the PE; counts delivered packets.
module gin_multicast_buffer_ctrl #(
  parameter int unsigned ID_LEN    = 4,
  parameter int unsigned VALUE_LEN = 32,
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned CNT_LEN   = 16,
  parameter int unsigned MA_X      = 0,
  parameter int unsigned MA_Y      = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_id,
  input  logic [2*ID_LEN-1:0]   id_in,
  output logic [2*ID_LEN-1:0]   id,
  output logic [CNT_LEN-1:0]    recv_cnt,
  gin_multicast_buffer_ctrl_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("gin_multicast_buffer_ctrl (%0d,%0d): DEPTH must be a power of 2 >= 2", MA_X, MA_Y);
  end

  logic [VALUE_LEN-1:0] mem [DEPTH];
  logic [AW:0]          wr_ptr;
  logic [AW:0]          rd_ptr;
  logic [ID_LEN-1:0]    id_lo;
  logic [ID_LEN-1:0]    id_hi;
  logic                 full;
  logic                 empty;
  logic                 match;
  logic                 push;
  logic                 pop;

  assign id_lo = id[ID_LEN-1:0];
  assign id_hi = id[2*ID_LEN-1:ID_LEN];

  always_comb begin
    full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    empty = (wr_ptr == rd_ptr);
    // Empty window (id_hi < id_lo) falls out naturally: no tag satisfies both bounds.
    match = (bus.tag >= id_lo) && (bus.tag <= id_hi);
    push  = bus.in_valid && !full && match;
    pop   = !empty && bus.out_ready;
  end

  assign bus.in_ready  = !full;
  assign bus.out_valid = !empty;
  assign bus.value_out = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      id       <= '0;
      recv_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
      if (set_id) id <= id_in;
      if (set_id) begin
        recv_cnt <= '0;
      end else if (push && recv_cnt != '1) begin
        recv_cnt <= recv_cnt + {{(CNT_LEN-1){1'b0}}, 1'b1};
      end
    end
  end

  // Storage is not reset: a flush only needs the pointers cleared.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.value_in;
  end
endmodule

// File: tb/tb_gin_multicast_buffer_ctrl.sv
// Scoreboard bench for gin_multicast_buffer_ctrl: directed packets, monitor checks drained values.
module tb_gin_multicast_buffer_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        set_id = 1'b0;
  logic [7:0]  id_in = '0;
  logic [7:0]  id;
  logic [15:0] recv_cnt;
  logic        set_id2 = 1'b0;
  logic [7:0]  id_in2 = '0;
  logic [7:0]  id2;
  logic [1:0]  cnt2;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  gin_multicast_buffer_ctrl_if #(.ID_LEN(4), .VALUE_LEN(32)) bus ();
  gin_multicast_buffer_ctrl_if #(.ID_LEN(4), .VALUE_LEN(32)) bus2 ();

  gin_multicast_buffer_ctrl #(.ID_LEN(4), .VALUE_LEN(32), .DEPTH(2), .CNT_LEN(16), .MA_X(0), .MA_Y(0)) dut (
    .clk(clk), .rst(rst), .set_id(set_id), .id_in(id_in), .id(id),
    .recv_cnt(recv_cnt), .bus(bus)
  );

  gin_multicast_buffer_ctrl #(.ID_LEN(4), .VALUE_LEN(32), .DEPTH(2), .CNT_LEN(2), .MA_X(1), .MA_Y(0)) dut2 (
    .clk(clk), .rst(rst), .set_id(set_id2), .id_in(id_in2), .id(id2),
    .recv_cnt(cnt2), .bus(bus2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Monitor: compares every drained head against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got %0h required none", bus.value_out);
          end else begin
            chk("value_out", bus.value_out, exp_q.pop_front());
          end
        end else if (!bus.out_valid) begin
          chk("value_out_idle", bus.value_out, 32'h0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic set_window(input logic [7:0] w);
    set_id = 1'b1;
    id_in  = w;
    @(posedge clk); #1;
    set_id = 1'b0;
  endtask

  task automatic send(input logic [3:0] t, input logic [31:0] v, input bit m);
    bus.tag      = t;
    bus.value_in = v;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20 && !bus.in_ready; n++) begin
      @(posedge clk); #1;
    end
    if (!bus.in_ready) chk("send_in_ready_timeout", 32'(bus.in_ready), 32'h1);
    if (m) exp_q.push_back(v);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bus.out_ready = 1'b1;
    for (int n = 0; n < 40 && (exp_q.size() != 0 || bus.out_valid); n++) begin
      @(posedge clk); #1;
    end
    chk("drain_queue", 32'(exp_q.size()), 32'h0);
    chk("drain_out_valid", 32'(bus.out_valid), 32'h0);
  endtask

  initial begin
    logic [1:0] sat_exp [5];
    sat_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    bus.tag = '0;  bus.in_valid = 1'b0;  bus.value_in = '0;  bus.out_ready = 1'b0;
    bus2.tag = '0; bus2.in_valid = 1'b0; bus2.value_in = '0; bus2.out_ready = 1'b1;

    // Reset values
    #12;
    chk("rst_id", 32'(id), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_value_out", bus.value_out, 32'h0);
    chk("rst_recv_cnt", 32'(recv_cnt), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Exact match window [3,3]
    set_window(8'h33);
    chk("id_loaded", 32'(id), 32'h33);
    bus.out_ready = 1'b1;
    send(4'd3, 32'hA5A5_A5A5, 1'b1);
    chk("t1_out_valid_latency", 32'(bus.out_valid), 32'h1);
    chk("t1_recv_cnt", 32'(recv_cnt), 32'h1);
    send(4'd2, 32'hDEAD_BEEF, 1'b0);
    chk("t1_nomatch_out_valid", 32'(bus.out_valid), 32'h0);
    chk("t1_nomatch_recv_cnt", 32'(recv_cnt), 32'h1);

    // Range window [2,5], back-to-back
    set_window(8'h52);
    chk("t2_cnt_cleared", 32'(recv_cnt), 32'h0);
    send(4'd1, 32'd1, 1'b0);
    send(4'd2, 32'd2, 1'b1);
    chk("t2_in_ready_a", 32'(bus.in_ready), 32'h1);
    send(4'd5, 32'd3, 1'b1);
    send(4'd6, 32'd4, 1'b0);
    chk("t2_in_ready_b", 32'(bus.in_ready), 32'h1);
    send(4'd4, 32'd5, 1'b1);
    chk("t2_in_ready_c", 32'(bus.in_ready), 32'h1);
    chk("t2_recv_cnt", 32'(recv_cnt), 32'h3);
    wait_drain();

    // Backpressure: fill DEPTH=2, third packet held
    bus.out_ready = 1'b0;
    send(4'd3, 32'h10, 1'b1);
    send(4'd3, 32'h11, 1'b1);
    chk("t3_full_in_ready", 32'(bus.in_ready), 32'h0);
    chk("t3_full_out_valid", 32'(bus.out_valid), 32'h1);
    bus.tag = 4'd3; bus.value_in = 32'h12; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    chk("t3_held_in_ready", 32'(bus.in_ready), 32'h0);
    chk("t3_held_recv_cnt", 32'(recv_cnt), 32'h5);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("t3_in_ready_after_pop", 32'(bus.in_ready), 32'h1);
    exp_q.push_back(32'h12);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("t3_refull_in_ready", 32'(bus.in_ready), 32'h0);
    chk("t3_recv_cnt", 32'(recv_cnt), 32'h6);
    wait_drain();

    // set_id concurrent with a packet matched under the old window
    set_window(8'h33);
    bus.out_ready = 1'b0;
    send(4'd3, 32'h20, 1'b1);
    bus.tag = 4'd3; bus.value_in = 32'h21; bus.in_valid = 1'b1;
    set_id = 1'b1; id_in = 8'h77;
    exp_q.push_back(32'h21);
    @(posedge clk); #1;
    bus.in_valid = 1'b0; set_id = 1'b0;
    chk("t4_set_id_priority_cnt", 32'(recv_cnt), 32'h0);
    chk("t4_new_id", 32'(id), 32'h77);
    chk("t4_out_valid", 32'(bus.out_valid), 32'h1);
    bus.out_ready = 1'b1;
    send(4'd7, 32'h22, 1'b1);
    chk("t4_new_match_cnt", 32'(recv_cnt), 32'h1);
    send(4'd3, 32'h23, 1'b0);
    chk("t4_old_tag_dropped_cnt", 32'(recv_cnt), 32'h1);
    wait_drain();

    // Asynchronous reset flushes a full FIFO
    bus.out_ready = 1'b0;
    send(4'd7, 32'h30, 1'b1);
    send(4'd7, 32'h31, 1'b1);
    chk("t5_full_in_ready", 32'(bus.in_ready), 32'h0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("t5_rst_value_out", bus.value_out, 32'h0);
    chk("t5_rst_recv_cnt", 32'(recv_cnt), 32'h0);
    chk("t5_rst_in_ready", 32'(bus.in_ready), 32'h1);
    exp_q.delete();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t5_rst_id", 32'(id), 32'h0);
    bus.out_ready = 1'b1;
    send(4'd0, 32'h40, 1'b1);
    chk("t5_after_rst_cnt", 32'(recv_cnt), 32'h1);
    wait_drain();

    // Saturating counter, CNT_LEN = 2 (reset window [0,0] matches tag 0)
    for (int i = 0; i < 5; i++) begin
      bus2.tag = 4'd0; bus2.value_in = 32'(i); bus2.in_valid = 1'b1;
      @(posedge clk); #1;
      chk("t6_sat_cnt", 32'(cnt2), 32'(sat_exp[i]));
    end
    bus2.in_valid = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/gin_multicast_buffer_ctrl.md
# gin_multicast_buffer_ctrl

Buffered, range-matching successor to the GIN multicast controller, instantiated once per PE at the leaf of the Global Interconnect Network. It matches each bus packet's tag against a programmable ID window [id_lo, id_hi], stores matching values in a DEPTH-entry FIFO, and drains them to the PE with a valid/ready handshake. This decouples bus timing from PE consumption. The window is loaded through the existing set_id scan chain, and a saturating counter records delivered packets.

## Interface
- ID_LEN, 4, tag/ID width
- VALUE_LEN, 32, payload width
- DEPTH, 2, FIFO entries; power of 2, ≥2
- CNT_LEN, 16, delivered-packet counter width
- MA_X, 0, machine address X (debug only, no logic effect)
- MA_Y, 0, machine address Y (debug only, no logic effect)

- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- set_id  in  1  load ID window this cycle
- id_in  in  2*ID_LEN  scan-chain input {hi, lo}
- id  out  2*ID_LEN  registered {id_hi, id_lo}, feeds the next PE's id_in
- tag  in  ID_LEN  packet destination tag
- in_valid  in  1  bus packet present
- in_ready  out  1  FIFO can accept (= !full)
- value_in  in  VALUE_LEN  bus payload
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  PE consumes head
- value_out  out  VALUE_LEN  FIFO head when out_valid, else 0
- recv_cnt  out  CNT_LEN  matched packets accepted since reset/set_id

## Operation
- match = (id_lo ≤ tag ≤ id_hi), unsigned compare. Exact multicast is the case id_lo == id_hi. If id_hi < id_lo, nothing matches.
- push = in_valid & in_ready & match. Writes value_in at the write pointer.
- A packet with in_valid & in_ready & !match is accepted and dropped: no store, no count.
- pop = out_valid & out_ready. Advances the read pointer.
- Pointers are log2(DEPTH)+1 bits and wrap naturally.
- full = MSBs differ and lower bits are equal. empty = pointers equal.
- in_ready = !full. A pop in the same cycle does not make in_ready high (no pop-through), so in_ready never depends combinationally on out_ready.
- Simultaneous push and pop when not full and not empty: count unchanged, both pointers advance.
- Simultaneous push and pop when empty is impossible, because out_valid = 0.
- recv_cnt increments on push and saturates at 2^CNT_LEN−1. It is cleared to 0 when set_id is high, and set_id takes priority over a same-cycle push.
- On set_id: {id_hi, id_lo} ← id_in at the clock edge.
  - A packet in the same cycle is matched against the old window.
  - FIFO contents are preserved.
- value_out is forced to 0 whenever out_valid = 0.

## Timing
- Reset values:
  - id = 0 (window [0,0])
  - pointers = 0
  - out_valid = 0
  - in_ready = 1
  - value_out = 0
  - recv_cnt = 0
- Reset asserted mid-operation flushes the FIFO immediately (asynchronously). Stored data is discarded, not drained.
- Push-to-out_valid latency is 1 cycle: there is no combinational bypass from value_in to value_out.
- Pop: the next entry appears on value_out in the same cycle the read pointer advances, i.e. the cycle after the pop edge.
- Throughput is 1 packet/cycle in steady state when DEPTH ≥ 2 and out_ready is held high.
- in_ready and out_valid are functions of registered pointers only.
- id and recv_cnt are registered and update 1 cycle after their causing event.

## Test plan
- Reset, then set_id with id_in = {4'd3, 4'd3}. Send tag 3, value 0xA5A5A5A5, out_ready = 1 → out_valid high 1 cycle later with value_out = 0xA5A5A5A5; recv_cnt = 1. Then send tag 2 → out_valid stays 0 and recv_cnt stays 1.
- Window [2,5]. Send tags 1,2,5,6,4 back-to-back with values 1..5 and out_ready = 1 → outputs 2, 3, 5 in order; recv_cnt = 3; in_ready stays 1 throughout.
- DEPTH = 2, out_ready = 0. Push 3 matching packets → in_ready drops after the 2nd push and the 3rd is held by the bus. Then raise out_ready for 1 cycle → in_ready returns to 1 the following cycle; values come out in FIFO order.
- FIFO holds 1 entry. Assert set_id with window [7,7] in the same cycle as a tag-3 packet under the old window [3,3] → the packet is stored; recv_cnt = 0 next cycle; the old entry is still output; subsequent tag 7 matches.
- Fill the FIFO, then pulse rst mid-cycle → out_valid, value_out and recv_cnt go to 0 immediately and in_ready goes to 1. After release, a matching tag-0 packet is accepted.
- CNT_LEN = 2. Push 5 matching packets → recv_cnt reads 1, 2, 3, 3, 3.
